// File: rtl/dilithium_core.sv
// Key-generation I/O sequencer: loads a 256-bit seed into the arithmetic engine,
// waits for it, then streams the packed secret and public key out over valid/ready.
module dilithium_core #(
    parameter  int HIGH_PERF = 0,
    parameter  int SEC_LEVEL = 5,
    localparam int W         = (HIGH_PERF != 0) ? 64 : 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [1:0]   mode,
    input  logic         valid_i,
    output logic         ready_i,
    input  logic [W-1:0] data_i,
    output logic         valid_o,
    input  logic         ready_o,
    output logic [W-1:0] data_o,
    output logic         done,
    output logic         eng_start,
    output logic         eng_seed_we,
    output logic [2:0]   eng_seed_addr,
    output logic [W-1:0] eng_seed_data,
    input  logic         eng_done,
    output logic [2:0]   rd_seg,
    output logic [9:0]   rd_addr,
    output logic         rd_en,
    input  logic [W-1:0] rd_data
);

    localparam int SEED_WORDS = 256 / W;
    localparam int NSEG       = (HIGH_PERF != 0) ? 7 : 8;

    localparam int S1_BITS = (SEC_LEVEL == 2) ? 3072  : (SEC_LEVEL == 3) ? 5120  : 5376;
    localparam int S2_BITS = (SEC_LEVEL == 2) ? 3072  : 6144;
    localparam int T0_BITS = (SEC_LEVEL == 2) ? 13312 : (SEC_LEVEL == 3) ? 19968 : 26624;
    localparam int T1_BITS = (SEC_LEVEL == 2) ? 10240 : (SEC_LEVEL == 3) ? 15360 : 20480;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        DUMP,
        FIN
    } state_t;

    state_t         state;
    logic [2:0]     seed_idx;
    logic [2:0]     pos;
    logic [9:0]     addr;
    logic           fetch_done;
    logic           rd_pend;
    logic           skid_valid;
    logic [W-1:0]   skid_data;

    logic           take;
    logic           out_free;
    logic           nxt_valid_o;
    logic           nxt_skid_valid;
    logic           issue;
    logic           finish;
    logic [2:0]     cur_seg;
    logic           last_word;
    logic           last_seg;

    function automatic logic [9:0] words_of(input logic [2:0] seg);
        int bits;
        case (seg)
            3'd3:    bits = S1_BITS;
            3'd4:    bits = S2_BITS;
            3'd5:    bits = T0_BITS;
            3'd6:    bits = T1_BITS;
            default: bits = 256;
        endcase
        return 10'((bits + W - 1) / W);
    endfunction

    // Segment emitted at each position of the dump; the low-resource order sends rho twice.
    function automatic logic [2:0] seg_at(input logic [2:0] p);
        logic [2:0] s;
        if (HIGH_PERF != 0) begin
            case (p)
                3'd0:    s = 3'd0;
                3'd1:    s = 3'd1;
                3'd2:    s = 3'd3;
                3'd3:    s = 3'd4;
                3'd4:    s = 3'd6;
                3'd5:    s = 3'd5;
                default: s = 3'd2;
            endcase
        end else begin
            case (p)
                3'd6:    s = 3'd0;
                3'd7:    s = 3'd6;
                default: s = p;
            endcase
        end
        return s;
    endfunction

    assign cur_seg   = seg_at(pos);
    assign last_word = (addr == words_of(cur_seg) - 10'd1);
    assign last_seg  = (pos == 3'(NSEG - 1));

    // Output register plus one skid entry; reads are only issued while the words
    // already in flight or held are fewer than two, so a returning read always has a slot.
    always_comb begin
        take           = valid_o && ready_o;
        out_free       = !valid_o || take;
        nxt_valid_o    = !out_free || skid_valid || rd_pend;
        nxt_skid_valid = out_free ? (skid_valid && rd_pend) : (skid_valid || rd_pend);
        issue          = 1'b0;
        finish         = 1'b0;
        if (state == DUMP) begin
            issue  = !fetch_done &&
                     (({1'b0, nxt_valid_o} + {1'b0, nxt_skid_valid} + {1'b0, rd_en}) < 2'd2);
            finish = fetch_done && !rd_en && !rd_pend && !skid_valid && out_free;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            ready_i       <= 1'b0;
            valid_o       <= 1'b0;
            data_o        <= '0;
            done          <= 1'b0;
            eng_start     <= 1'b0;
            eng_seed_we   <= 1'b0;
            eng_seed_addr <= '0;
            eng_seed_data <= '0;
            rd_en         <= 1'b0;
            rd_seg        <= '0;
            rd_addr       <= '0;
            seed_idx      <= '0;
            pos           <= '0;
            addr          <= '0;
            fetch_done    <= 1'b0;
            rd_pend       <= 1'b0;
            skid_valid    <= 1'b0;
            skid_data     <= '0;
        end else begin
            eng_start   <= 1'b0;
            eng_seed_we <= 1'b0;
            done        <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && mode == 2'd0) begin
                        state    <= LOAD;
                        ready_i  <= 1'b1;
                        seed_idx <= '0;
                    end
                end
                LOAD: begin
                    if (valid_i && ready_i) begin
                        eng_seed_we   <= 1'b1;
                        eng_seed_addr <= seed_idx;
                        eng_seed_data <= data_i;
                        seed_idx      <= seed_idx + 3'd1;
                        if (seed_idx == 3'(SEED_WORDS - 1)) begin
                            ready_i   <= 1'b0;
                            eng_start <= 1'b1;
                            state     <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (eng_done) begin
                        state      <= DUMP;
                        pos        <= '0;
                        addr       <= '0;
                        fetch_done <= 1'b0;
                    end
                end
                DUMP: begin
                    valid_o    <= nxt_valid_o;
                    skid_valid <= nxt_skid_valid;
                    rd_pend    <= rd_en;
                    rd_en      <= issue;
                    if (out_free && (skid_valid || rd_pend)) begin
                        data_o <= skid_valid ? skid_data : rd_data;
                    end
                    if (rd_pend && (skid_valid || !out_free)) begin
                        skid_data <= rd_data;
                    end
                    if (issue) begin
                        rd_seg  <= cur_seg;
                        rd_addr <= addr;
                        if (last_word) begin
                            addr <= '0;
                            pos  <= pos + 3'd1;
                            if (last_seg) begin
                                fetch_done <= 1'b1;
                            end
                        end else begin
                            addr <= addr + 10'd1;
                        end
                    end
                    if (finish) begin
                        state <= FIN;
                        done  <= 1'b1;
                    end
                end
                FIN: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dilithium_core.sv
// Bench for dilithium_core: a low-resource (level 5) and a high-perf (level 2) instance
// share stimulus through a select mux and are checked against a segment-table model.
module tb_dilithium_core;

    typedef struct {
        bit sel;
        bit stall;
        int exp_words;
        int exp_seed_words;
    } vec_t;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        sel;
    logic        start;
    logic [1:0]  mode;
    logic        valid_i;
    logic [63:0] data_i;
    logic        ready_o;
    logic        eng_model_done;
    logic        force_done;
    logic        eng_done;
    logic [63:0] rd_data;
    logic [15:0] cur_tag;

    logic        ready_i0, valid_o0, done0, eng_start0, eng_seed_we0, rd_en0;
    logic [2:0]  eng_seed_addr0, rd_seg0;
    logic [9:0]  rd_addr0;
    logic [31:0] data_o0, eng_seed_data0;
    logic        ready_i1, valid_o1, done1, eng_start1, eng_seed_we1, rd_en1;
    logic [2:0]  eng_seed_addr1, rd_seg1;
    logic [9:0]  rd_addr1;
    logic [63:0] data_o1, eng_seed_data1;

    logic        start0, start1, valid_i0, valid_i1, ready_o0, ready_o1, eng_done0, eng_done1;
    logic        m_ready_i, m_valid_o, m_done, m_eng_start, m_seed_we, m_rd_en;
    logic [2:0]  m_seed_addr, m_rd_seg;
    logic [9:0]  m_rd_addr;
    logic [63:0] m_data_o, m_seed_data;

    assign eng_done  = eng_model_done || force_done;
    assign start0    = start && !sel;
    assign start1    = start && sel;
    assign valid_i0  = valid_i && !sel;
    assign valid_i1  = valid_i && sel;
    assign ready_o0  = ready_o && !sel;
    assign ready_o1  = ready_o && sel;
    assign eng_done0 = eng_done && !sel;
    assign eng_done1 = eng_done && sel;

    assign m_ready_i   = sel ? ready_i1 : ready_i0;
    assign m_valid_o   = sel ? valid_o1 : valid_o0;
    assign m_done      = sel ? done1 : done0;
    assign m_eng_start = sel ? eng_start1 : eng_start0;
    assign m_seed_we   = sel ? eng_seed_we1 : eng_seed_we0;
    assign m_rd_en     = sel ? rd_en1 : rd_en0;
    assign m_seed_addr = sel ? eng_seed_addr1 : eng_seed_addr0;
    assign m_rd_seg    = sel ? rd_seg1 : rd_seg0;
    assign m_rd_addr   = sel ? rd_addr1 : rd_addr0;
    assign m_data_o    = sel ? data_o1 : {32'b0, data_o0};
    assign m_seed_data = sel ? eng_seed_data1 : {32'b0, eng_seed_data0};

    dilithium_core #(.HIGH_PERF(0), .SEC_LEVEL(5)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .mode(mode),
        .valid_i(valid_i0), .ready_i(ready_i0), .data_i(data_i[31:0]),
        .valid_o(valid_o0), .ready_o(ready_o0), .data_o(data_o0), .done(done0),
        .eng_start(eng_start0), .eng_seed_we(eng_seed_we0), .eng_seed_addr(eng_seed_addr0),
        .eng_seed_data(eng_seed_data0), .eng_done(eng_done0),
        .rd_seg(rd_seg0), .rd_addr(rd_addr0), .rd_en(rd_en0), .rd_data(rd_data[31:0])
    );

    dilithium_core #(.HIGH_PERF(1), .SEC_LEVEL(2)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .mode(mode),
        .valid_i(valid_i1), .ready_i(ready_i1), .data_i(data_i),
        .valid_o(valid_o1), .ready_o(ready_o1), .data_o(data_o1), .done(done1),
        .eng_start(eng_start1), .eng_seed_we(eng_seed_we1), .eng_seed_addr(eng_seed_addr1),
        .eng_seed_data(eng_seed_data1), .eng_done(eng_done1),
        .rd_seg(rd_seg1), .rd_addr(rd_addr1), .rd_en(rd_en1), .rd_data(rd_data)
    );

    int          passed = 0;
    int          total  = 0;
    logic [63:0] exp_q[$];
    int          ord_lo[8] = '{0, 1, 2, 3, 4, 5, 0, 6};
    int          ord_hi[8] = '{0, 1, 3, 4, 6, 5, 2, 0};
    vec_t        vecs[4];

    function automatic logic [63:0] engWord(input logic [15:0] t, input logic [2:0] s,
                                            input logic [9:0] a);
        logic [31:0] lo;
        lo = {t, 3'b000, s, a};
        return {~lo, lo};
    endfunction

    function automatic logic [63:0] seedWord(input logic [255:0] s, input bit hp, input int i);
        if (hp) return s[255 - 64 * i -: 64];
        return {32'b0, s[255 - 32 * i -: 32]};
    endfunction

    function automatic int segBits(input int seg, input int lvl);
        case (seg)
            3: return (lvl == 2) ? 3072 : (lvl == 3) ? 5120 : 5376;
            4: return (lvl == 2) ? 3072 : 6144;
            5: return (lvl == 2) ? 13312 : (lvl == 3) ? 19968 : 26624;
            6: return (lvl == 2) ? 10240 : (lvl == 3) ? 15360 : 20480;
            default: return 256;
        endcase
    endfunction

    task automatic buildExpected(input bit hp, input logic [15:0] t);
        int w, lvl, nseg, seg, nw;
        logic [63:0] v;
        w    = hp ? 64 : 32;
        lvl  = hp ? 2 : 5;
        nseg = hp ? 7 : 8;
        exp_q.delete();
        for (int p = 0; p < nseg; p++) begin
            seg = hp ? ord_hi[p] : ord_lo[p];
            nw  = (segBits(seg, lvl) + w - 1) / w;
            for (int a = 0; a < nw; a++) begin
                v = engWord(t, 3'(seg), 10'(a));
                exp_q.push_back(hp ? v : {32'b0, v[31:0]});
            end
        end
    endtask

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end else begin
            passed++;
        end
    endtask

    // Engine stand-in: answers each read one cycle later, raises eng_done 30 cycles after eng_start.
    initial begin
        int          dcnt;
        logic        p;
        logic [2:0]  ps;
        logic [9:0]  pa;
        dcnt           = 0;
        rd_data        = 64'hBAD0_BAD0_BAD0_BAD0;
        eng_model_done = 1'b0;
        forever begin
            @(negedge clk);
            p  = m_rd_en;
            ps = m_rd_seg;
            pa = m_rd_addr;
            if (m_eng_start) dcnt = 30;
            @(posedge clk);
            #1;
            rd_data = p ? engWord(cur_tag, ps, pa) : 64'hBAD0_BAD0_BAD0_BAD0;
            if (dcnt > 0) begin
                dcnt--;
                eng_model_done = (dcnt == 0);
            end else begin
                eng_model_done = 1'b0;
            end
        end
    end

    task automatic applyStimulus(input vec_t v, input int abort_at);
        logic [255:0] seed;
        logic [63:0]  w0, prev_data, first_got, first_exp;
        int idx, cyc, rdy_cnt, we_cnt, we_bad, est_cnt, est_cyc, last_we_cyc, vo_load;
        int got, mism, unstable, dones, extra_done, extra_valid;
        bit prev_stall, seen_done;

        for (int k = 0; k < 8; k++) seed[k * 32 +: 32] = $urandom;
        sel     = v.sel;
        w0      = seedWord(seed, v.sel, 0);
        cur_tag = w0[15:0];
        buildExpected(v.sel, cur_tag);

        @(posedge clk); #1;
        start = 1'b1;
        mode  = 2'd0;
        @(posedge clk); #1;
        start   = 1'b0;
        idx     = 0;
        valid_i = 1'b1;
        data_i  = seedWord(seed, v.sel, 0);
        rdy_cnt = 0; we_cnt = 0; we_bad = 0; est_cnt = 0; est_cyc = -1; last_we_cyc = -1; vo_load = 0;
        for (cyc = 0; cyc < 20; cyc++) begin
            @(negedge clk);
            if (m_ready_i) rdy_cnt++;
            if (m_valid_o) vo_load++;
            if (m_eng_start) begin est_cnt++; est_cyc = cyc; end
            if (m_seed_we) begin
                if (m_seed_addr != 3'(we_cnt) || m_seed_data !== seedWord(seed, v.sel, we_cnt)) we_bad++;
                we_cnt++;
                last_we_cyc = cyc;
            end
            if (m_ready_i && valid_i) idx++;
            @(posedge clk); #1;
            valid_i = (idx < v.exp_seed_words);
            data_i  = (idx < v.exp_seed_words) ? seedWord(seed, v.sel, idx) : 64'h0;
        end
        checkOutput("seed_ready_cycles", 64'(rdy_cnt), 64'(v.exp_seed_words));
        checkOutput("seed_write_count", 64'(we_cnt), 64'(v.exp_seed_words));
        checkOutput("seed_write_bad", 64'(we_bad), 64'd0);
        checkOutput("eng_start_count", 64'(est_cnt), 64'd1);
        checkOutput("eng_start_after_seed", 64'(est_cyc >= last_we_cyc && last_we_cyc >= 0), 64'd1);
        checkOutput("valid_o_before_dump", 64'(vo_load), 64'd0);

        got = 0; mism = 0; unstable = 0; dones = 0; prev_stall = 0; seen_done = 0;
        prev_data = '0; first_got = '0; first_exp = '0;
        for (int c = 0; c < 20000 && !seen_done; c++) begin
            @(posedge clk); #1;
            if (abort_at >= 0 && got == abort_at) begin
                rst = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0;
                @(negedge clk);
                checkOutput("abort_valid_o", 64'(m_valid_o), 64'd0);
                checkOutput("abort_done", 64'(m_done), 64'd0);
                checkOutput("abort_out_data", m_data_o, 64'd0);
                extra_valid = 0;
                for (int k = 0; k < 4; k++) begin
                    @(negedge clk);
                    if (m_ready_i || m_valid_o || m_done || m_rd_en) extra_valid++;
                end
                checkOutput("abort_idle_quiet", 64'(extra_valid), 64'd0);
                ready_o = 1'b0;
                return;
            end
            ready_o = v.stall ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            if (prev_stall && (!m_valid_o || m_data_o !== prev_data)) unstable++;
            if (m_valid_o && ready_o) begin
                if (exp_q.size() == 0) begin
                    mism++;
                end else begin
                    first_exp = exp_q.pop_front();
                    if (m_data_o !== first_exp) begin
                        if (mism == 0) $display("[TB] word %0d: got %h, expected %h", got, m_data_o, first_exp);
                        mism++;
                    end
                end
                got++;
            end
            prev_stall = m_valid_o && !ready_o;
            prev_data  = m_data_o;
            if (m_done) begin
                dones++;
                seen_done = 1;
            end
        end
        ready_o = 1'b0;
        extra_done = 0; extra_valid = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (m_done) extra_done++;
            if (m_valid_o) extra_valid++;
        end
        checkOutput("done_seen", 64'(seen_done), 64'd1);
        checkOutput("dump_word_count", 64'(got), 64'(v.exp_words));
        checkOutput("dump_data_mismatches", 64'(mism), 64'd0);
        checkOutput("dump_words_missing", 64'(exp_q.size()), 64'd0);
        checkOutput("stall_stability", 64'(unstable), 64'd0);
        checkOutput("done_single_pulse", 64'(extra_done), 64'd0);
        checkOutput("valid_o_after_done", 64'(extra_valid), 64'd0);
    endtask

    initial begin
        int bad;
        vecs[0] = '{sel: 1'b0, stall: 1'b0, exp_words: 1864, exp_seed_words: 8};
        vecs[1] = '{sel: 1'b0, stall: 1'b1, exp_words: 1864, exp_seed_words: 8};
        vecs[2] = '{sel: 1'b1, stall: 1'b0, exp_words: 476,  exp_seed_words: 4};
        vecs[3] = '{sel: 1'b1, stall: 1'b1, exp_words: 476,  exp_seed_words: 4};

        rst = 1'b1; sel = 1'b0; start = 1'b0; mode = 2'd0; valid_i = 1'b0; data_i = '0;
        ready_o = 1'b0; force_done = 1'b0; cur_tag = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel = 1'(s);
            #1;
            checkOutput(s ? "reset_ctrl_hp" : "reset_ctrl_lo",
                        64'({m_ready_i, m_valid_o, m_done, m_eng_start, m_seed_we, m_rd_en}), 64'd0);
            checkOutput(s ? "reset_data_hp" : "reset_data_lo", m_data_o, 64'd0);
        end
        sel = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;

        // Non-keygen mode, stray valid_i and stray eng_done in IDLE must all be ignored.
        start = 1'b1; mode = 2'd1; valid_i = 1'b1; force_done = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; mode = 2'd0; force_done = 1'b0;
        bad = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (m_ready_i || m_eng_start || m_valid_o || m_seed_we || m_rd_en) bad++;
            @(posedge clk); #1;
            force_done = (k == 5);
        end
        valid_i = 1'b0;
        checkOutput("mode1_ignored", 64'(bad), 64'd0);

        for (int i = 0; i < 4; i++) applyStimulus(vecs[i], -1);

        applyStimulus(vecs[0], 400);
        applyStimulus(vecs[0], -1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/dilithium_core.md
Name: dilithium_core

Overview:
- Top-level key-generation I/O sequencer of the Dilithium accelerator, sitting between the external streaming bus and the arithmetic engine (SHAKE, NTT and packing are sibling blocks).
- Accepts a 256-bit seed as W-bit words and hands it to the engine. Waits for the engine to finish.
- Streams the packed secret key, then the public key, back out as W-bit words over a valid/ready handshake.

Parameters:
- HIGH_PERF, 0: 0 selects low-resource variant (W=32, sk-then-pk order); 1 selects high-perf variant (W=64, interleaved order).
- SEC_LEVEL, 5: Dilithium level 2, 3 or 5; sets segment sizes.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle request to begin an operation
- mode  in  2  operation select; 0 = key generation
- valid_i  in  1  data_i holds a valid seed word
- ready_i  out  1  block accepts a seed word this cycle
- data_i  in  W  seed word
- valid_o  out  1  data_o holds a valid result word
- ready_o  in  1  consumer accepts data_o this cycle
- data_o  out  W  result word
- done  out  1  one-cycle pulse after the last result word
- eng_start  out  1  one-cycle pulse: seed loaded, engine runs
- eng_seed_we  out  1  seed word write strobe to engine
- eng_seed_addr  out  3  seed word index (0..SEED_WORDS-1)
- eng_seed_data  out  W  seed word to engine
- eng_done  in  1  engine finished; result RAM valid
- rd_seg  out  3  result segment: 0 rho, 1 K, 2 tr, 3 s1, 4 s2, 5 t0, 6 t1
- rd_addr  out  10  word index within segment
- rd_en  out  1  result read strobe
- rd_data  in  W  result word; returned 1 cycle after rd_en

Behaviour:
- W = 64 if HIGH_PERF else 32. Segment bit sizes:
  - s1: 3072 / 5120 / 5376 for levels 2 / 3 / 5.
  - s2: 3072 / 6144 / 6144.
  - t0: 13312 / 19968 / 26624.
  - t1: 10240 / 15360 / 20480.
  - rho, K, tr: 256 bits each.
- Word count per segment = ceil(bits/W); SEED_WORDS = 256/W.
- Word order: word i is bits [i*W +: W] with bit 0 the most significant bit of the byte string (first word = leftmost hex digits). The engine RAM is indexed the same way.
- Reset: ready_i, valid_o, done, eng_start, eng_seed_we and rd_en are all 0; data_o is 0; FSM goes to IDLE.
- Reset mid-operation aborts immediately with the same values.
- States:
  - IDLE: on start && mode==0, go to LOAD. A start with another mode is ignored and the FSM stays in IDLE.
  - LOAD: ready_i=1. Each cycle with valid_i && ready_i, write data_i to the engine at the current index and increment. After word SEED_WORDS-1, drop ready_i, pulse eng_start, go to RUN.
  - RUN: wait for eng_done, then go to DUMP.
  - DUMP: stream segments in order.
    - HIGH_PERF=0: rho, K, tr, s1, s2, t0 (secret key), then rho, t1 (public key); rho is sent twice.
    - HIGH_PERF=1: rho, K, s1, s2, t1, t0, tr.
  - FIN: pulse done for one cycle, return to IDLE.
- Output handshake:
  - A word transfers when valid_o && ready_o.
  - While valid_o && !ready_o, data_o and valid_o hold stable.
  - valid_o never asserts outside DUMP.
  - The word count per segment is exact; there are no gaps in the index sequence.
- Throughput: at least one word per 2 cycles under continuous ready_o. Bubbles are allowed; reordering is not.
- start while not IDLE is ignored. valid_i outside LOAD is ignored. eng_done outside RUN is ignored.
- After DUMP → FIN → IDLE, the next start performs a fresh keygen with no stale state.

Test Plan:
- Reset then idle, SEC_LEVEL=5, HIGH_PERF=0, mode=0, start pulse, 8 seed words with valid_i held high:
  - ready_i stays high for exactly 8 transfers, eng_seed_addr goes 0..7, then one eng_start pulse.
  - Bench engine model asserts eng_done and returns rd_data = {seg, addr}.
  - data_o must follow rho 0..7, K 0..7, tr 0..7, s1 0..167, s2 0..191, t0 0..831, rho 0..7, t1 0..639, then a single done pulse.
- Same flow with ready_o toggling pseudo-randomly: no word is dropped or duplicated, and data_o stays stable while stalled.
- HIGH_PERF=1, SEC_LEVEL=2: W=64; order rho 4, K 4, s1 48, s2 48, t1 160, t0 208, tr 4 words.
- start with mode=1 → no ready_i and no eng_start. Then start with mode=0 proceeds normally.
- Assert rst during t0 streaming → next cycle valid_o=0, done=0, FSM in IDLE. A new start runs a complete correct sequence.
- Two back-to-back keygens with different seeds → second eng_seed_data matches the new seed and the full dump repeats.
